// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour types and constants for the VGA layer compositor
package vga_pkg;

    localparam int COLOR_W = 12;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t TRANSPARENT = 12'hCBE;
    localparam color_t BLACK       = 12'h000;

endpackage

// File: rtl/vga_layer_compositor_if.sv
// rtl/vga_layer_compositor_if.sv - pixel-generator to compositor bus; overlap_count exists only with VGA_COMPOSITOR_OVERLAP_EN
interface vga_layer_compositor_if #(
    parameter int NUM_LAYERS = 6
);
    import vga_pkg::*;

    localparam int HIT_W = $clog2(NUM_LAYERS + 1);

    logic                          vga_valid;
    logic                          frame_start;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_pixels;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [NUM_LAYERS-1:0]         blink_mask;
    color_t                        bg_color;
    color_t                        pixel;
    logic                          pixel_valid;
    logic [HIT_W-1:0]              hit_layer;
`ifdef VGA_COMPOSITOR_OVERLAP_EN
    logic [15:0]                   overlap_count;

    modport master (
        output vga_valid, frame_start, layer_pixels, layer_en, blink_mask, bg_color,
        input  pixel, pixel_valid, hit_layer, overlap_count
    );
    modport slave (
        input  vga_valid, frame_start, layer_pixels, layer_en, blink_mask, bg_color,
        output pixel, pixel_valid, hit_layer, overlap_count
    );
`else
    modport master (
        output vga_valid, frame_start, layer_pixels, layer_en, blink_mask, bg_color,
        input  pixel, pixel_valid, hit_layer
    );
    modport slave (
        input  vga_valid, frame_start, layer_pixels, layer_en, blink_mask, bg_color,
        output pixel, pixel_valid, hit_layer
    );
`endif

endinterface

// File: rtl/layer_priority_enc.sv
// rtl/layer_priority_enc.sv - combinational lowest-set-bit encoder returning {found, index}
module layer_priority_enc #(
    parameter int NUM_LAYERS = 6,
    parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic [NUM_LAYERS-1:0] req_i,
    output logic                  found_o,
    output logic [IDX_W-1:0]      index_o
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// rtl/vga_layer_compositor.sv - 2-stage fixed-priority layer compositor; VGA_COMPOSITOR_OVERLAP_EN adds overlap_count
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int NUM_LAYERS   = 6,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_layer_compositor_if.slave  bus
);

    localparam int HIT_W = $clog2(NUM_LAYERS + 1);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int CNT_W = $clog2(BLINK_FRAMES);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(BLINK_FRAMES - 1);
    localparam cnt_t CNT_HALF = cnt_t'(BLINK_FRAMES / 2);
    localparam logic [HIT_W-1:0] HIT_BG = HIT_W'(NUM_LAYERS);

    logic [NUM_LAYERS-1:0] en_shadow_q, en_shadow_d;
    logic [NUM_LAYERS-1:0] blink_shadow_q, blink_shadow_d;
    cnt_t                  frame_cnt_q, frame_cnt_d;
    logic                  blink_off;

    color_t                layer_d [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] opaque_d;

    color_t                layer_q [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] opaque_q;
    logic                  valid1_q;
    color_t                bg1_q;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;

    color_t                pixel_q, pixel_d;
    logic                  pixel_valid_q;
    logic [HIT_W-1:0]      hit_q, hit_d;

    // Shadow state updates on the frame_start edge, so the frame_start pixel still sees old values.
    always_comb begin
        en_shadow_d    = en_shadow_q;
        blink_shadow_d = blink_shadow_q;
        frame_cnt_d    = frame_cnt_q;
        if (bus.frame_start) begin
            en_shadow_d    = bus.layer_en;
            blink_shadow_d = bus.blink_mask;
            frame_cnt_d    = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + cnt_t'(1);
        end
    end

    always_comb begin
        blink_off = (frame_cnt_q >= CNT_HALF);
        for (int i = 0; i < NUM_LAYERS; i++) begin
            layer_d[i]  = bus.layer_pixels[i*COLOR_W +: COLOR_W];
            opaque_d[i] = (layer_d[i] != TRANSPARENT) & en_shadow_q[i]
                        & ~(blink_shadow_q[i] & blink_off);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_shadow_q    <= '1;
            blink_shadow_q <= '0;
            frame_cnt_q    <= '0;
            opaque_q       <= '0;
            valid1_q       <= 1'b0;
            bg1_q          <= BLACK;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                layer_q[i] <= BLACK;
            end
        end else begin
            en_shadow_q    <= en_shadow_d;
            blink_shadow_q <= blink_shadow_d;
            frame_cnt_q    <= frame_cnt_d;
            opaque_q       <= opaque_d;
            valid1_q       <= bus.vga_valid;
            bg1_q          <= bus.bg_color;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                layer_q[i] <= layer_d[i];
            end
        end
    end

    layer_priority_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_prio (
        .req_i   (opaque_q),
        .found_o (win_found),
        .index_o (win_idx)
    );

    always_comb begin
        pixel_d = BLACK;
        hit_d   = HIT_BG;
        if (valid1_q) begin
            if (win_found) begin
                pixel_d = layer_q[win_idx];
                hit_d   = HIT_W'(win_idx);
            end else begin
                pixel_d = bg1_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q       <= BLACK;
            pixel_valid_q <= 1'b0;
            hit_q         <= HIT_BG;
        end else begin
            pixel_q       <= pixel_d;
            pixel_valid_q <= valid1_q;
            hit_q         <= hit_d;
        end
    end

    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.hit_layer   = hit_q;

`ifdef VGA_COMPOSITOR_OVERLAP_EN
    logic [15:0] ovl_cnt_q, ovl_cnt_d;
    logic [15:0] ovl_out_q, ovl_out_d;
    logic        ovl_hit;

    // Contact means the two top layers (player, monster) are both drawn on a visible pixel.
    always_comb begin
        ovl_hit   = bus.vga_valid & opaque_d[0] & opaque_d[1];
        ovl_cnt_d = ovl_cnt_q;
        ovl_out_d = ovl_out_q;
        if (bus.frame_start) begin
            ovl_out_d = ovl_cnt_q;
            ovl_cnt_d = {15'd0, ovl_hit};
        end else if (ovl_hit && (ovl_cnt_q != 16'hFFFF)) begin
            ovl_cnt_d = ovl_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovl_cnt_q <= '0;
            ovl_out_q <= '0;
        end else begin
            ovl_cnt_q <= ovl_cnt_d;
            ovl_out_q <= ovl_out_d;
        end
    end

    assign bus.overlap_count = ovl_out_q;
`endif

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised, pipelined successor to the fixed-priority VGA pixel mixer.
- Merges NUM_LAYERS colour layers into one VGA pixel. Layer 0 has the highest priority.
- Each layer has a per-layer enable and a blink control. Both are latched once per frame so sprites never tear mid-frame.
- Sits between the sprite/map pixel generators and {vgaRed, vgaGreen, vgaBlue}.

Parameters:
- NUM_LAYERS, 6, number of input layers; index 0 = top priority.
- COLOR_W, 12, bits per pixel (4:4:4 RGB).
- TRANSPARENT, 12'hCBE, colour key meaning "no pixel on this layer".
- BLINK_FRAMES, 16, blink period in frames; must be even and >= 2.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- vga_valid  in  1  current pixel is inside the visible area.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- layer_pixels  in  NUM_LAYERS*COLOR_W  flat bus; layer i occupies bits [i*COLOR_W +: COLOR_W].
- layer_en  in  NUM_LAYERS  requested layer enables; sampled on frame_start only.
- blink_mask  in  NUM_LAYERS  layers that blink; sampled on frame_start only.
- bg_color  in  COLOR_W  colour shown when every layer is transparent or disabled.
- pixel  out  COLOR_W  composited colour.
- pixel_valid  out  1  vga_valid delayed to align with pixel.
- hit_layer  out  $clog2(NUM_LAYERS+1)  index of the winning layer; NUM_LAYERS = background.

Behaviour:
- Reset (async, active-high) values:
  - pixel = 0, pixel_valid = 0, hit_layer = NUM_LAYERS.
  - en_shadow = all ones, blink_shadow = 0, frame_cnt = 0.
  - All pipeline registers cleared.
  - Deasserting rst mid-frame: output stays black until vga_valid propagates through the pipeline.
- Latency: exactly 2 cycles from inputs to pixel/pixel_valid/hit_layer. Throughput is one pixel per cycle, with no stalls.
- Stage 1 registers:
  - All layer pixels.
  - vga_valid.
  - bg_color.
  - opaque[i] = (layer i != TRANSPARENT) & en_shadow[i] & ~(blink_shadow[i] & blink_off).
- Stage 2 (fixed priority select):
  - Lowest i with opaque[i] set wins; pixel = layer i, hit_layer = i.
  - If no layer is opaque: pixel = bg_color, hit_layer = NUM_LAYERS.
  - If registered valid = 0: pixel = 0 (black), hit_layer = NUM_LAYERS.
- Frame counter:
  - On frame_start, frame_cnt = (frame_cnt == BLINK_FRAMES-1) ? 0 : frame_cnt+1.
  - blink_off = (frame_cnt >= BLINK_FRAMES/2).
- Shadow registers:
  - On frame_start, en_shadow <= layer_en and blink_shadow <= blink_mask.
  - The new values apply to pixels entering stage 1 on the cycle after frame_start. The pixel sampled in the frame_start cycle itself uses the old values.
- Boundary conditions:
  - A pixel equal to TRANSPARENT on a layer is always see-through, even when that layer is enabled.
  - All layers disabled -> bg_color on every valid pixel.
  - frame_start asserted on consecutive cycles -> each cycle counts as one frame.
  - frame_start while vga_valid = 1 is legal; it has no effect on the in-flight pixel.

Optional Feature:
- Macro: VGA_COMPOSITOR_OVERLAP_EN.
- Defined:
  - Adds port overlap_count, out, 16 bits.
  - An internal counter increments on each valid stage-1 pixel where opaque[0] & opaque[1] are both set (player/monster contact). It saturates at 16'hFFFF.
  - On frame_start, overlap_count <= counter and the counter clears to 0. If a qualifying pixel coincides with frame_start, it is counted into the new frame.
  - overlap_count resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - COLOR_W, TRANSPARENT.
  - BLACK = 12'h000.
  - A color_t typedef.
- Sub-module layer_priority_enc (parametrised by NUM_LAYERS): combinational lowest-set-bit encoder returning {found, index}. It is instantiated in stage 2.

Test Plan:
- Priority: layer0 = TRANSPARENT, layer1 = 12'hF00, layer2 = 12'h0F0, all enabled, valid = 1 -> 2 cycles later pixel = 12'hF00, hit_layer = 1.
- Invalid / background:
  - vga_valid = 0 with layer0 = 12'hFFF -> pixel = 0.
  - All layers = 12'hCBE with bg_color = 12'h123 -> pixel = 12'h123, hit_layer = 6.
- Enable shadow: change layer_en from 6'h3F to 6'h3E mid-frame -> layer0 is still shown. After frame_start, a layer0 pixel of 12'hABC falls through to layer1.
- Blink: blink_mask = 6'h02, BLINK_FRAMES = 4 -> layer1 visible for 2 frames, hidden for 2 frames, repeating.
- Async reset: assert rst mid-stream, between clock edges -> pixel = 0, pixel_valid = 0, hit_layer = 6 immediately. After release, the first valid output appears 2 cycles after valid input.
- Overlap (macro defined): 10 pixels with layer0 and layer1 both opaque, then frame_start -> overlap_count = 10 and the internal counter clears.
